// File: rtl/fp_addsub_pkg.sv
// Shared types and field helpers for the multi-cycle FP add/sub sequencer.
// Field helpers take a zero-extended 64-bit word so one definition serves any format width.
package fp_addsub_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

    localparam int unsigned EXP_WIDTH_DEF = 8;
    localparam int unsigned MAN_WIDTH_DEF = 23;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return exp_w + man_w + 1;
    endfunction

    function automatic logic [63:0] fp_exp_max(input int unsigned exp_w);
        return (64'd1 << exp_w) - 64'd1;
    endfunction

    function automatic logic fp_sign(input logic [63:0] word, input int unsigned exp_w,
                                     input int unsigned man_w);
        return 1'(word >> (exp_w + man_w));
    endfunction

    function automatic logic [63:0] fp_exp(input logic [63:0] word, input int unsigned exp_w,
                                           input int unsigned man_w);
        return (word >> man_w) & fp_exp_max(exp_w);
    endfunction

    function automatic logic [63:0] fp_man(input logic [63:0] word, input int unsigned man_w);
        return word & ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_exp_align.sv
// Combinational magnitude compare, swap and saturating right-shift alignment.
// X is always the larger-magnitude operand; Y's mantissa is pre-shifted to X's exponent.
module fp_exp_align
    import fp_addsub_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int unsigned MAN_WIDTH = MAN_WIDTH_DEF
) (
    input  logic [EXP_WIDTH+MAN_WIDTH:0] i_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] i_b,
    output logic                         o_special,
    output logic                         o_sign_x,
    output logic                         o_sign_y,
    output logic                         o_opp_tie,
    output logic [EXP_WIDTH-1:0]         o_exp_x,
    output logic [MAN_WIDTH:0]           o_man_x,
    output logic [MAN_WIDTH:0]           o_man_y
);
    localparam int unsigned W = fp_width(EXP_WIDTH, MAN_WIDTH);
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'(fp_exp_max(EXP_WIDTH));

    logic                 w_sign_a, w_sign_b, w_a_ge_b;
    logic [EXP_WIDTH-1:0] w_exp_a, w_exp_b, w_exp_y, w_diff;
    logic [MAN_WIDTH-1:0] w_frac_a, w_frac_b;
    logic [MAN_WIDTH:0]   w_man_a, w_man_b, w_man_y;

    assign w_sign_a = fp_sign(64'(i_a), EXP_WIDTH, MAN_WIDTH);
    assign w_sign_b = fp_sign(64'(i_b), EXP_WIDTH, MAN_WIDTH);
    assign w_exp_a  = EXP_WIDTH'(fp_exp(64'(i_a), EXP_WIDTH, MAN_WIDTH));
    assign w_exp_b  = EXP_WIDTH'(fp_exp(64'(i_b), EXP_WIDTH, MAN_WIDTH));
    assign w_frac_a = MAN_WIDTH'(fp_man(64'(i_a), MAN_WIDTH));
    assign w_frac_b = MAN_WIDTH'(fp_man(64'(i_b), MAN_WIDTH));

    // Zero exponent flushes the operand (denormals included) to a zero mantissa.
    assign w_man_a = (w_exp_a == '0) ? '0 : {1'b1, w_frac_a};
    assign w_man_b = (w_exp_b == '0) ? '0 : {1'b1, w_frac_b};

    assign w_a_ge_b  = (i_a[W-2:0] >= i_b[W-2:0]);
    assign o_special = (w_exp_a == EXP_MAX) || (w_exp_b == EXP_MAX);
    assign o_opp_tie = (i_a[W-2:0] == i_b[W-2:0]) && (w_sign_a != w_sign_b);

    assign o_sign_x = w_a_ge_b ? w_sign_a : w_sign_b;
    assign o_sign_y = w_a_ge_b ? w_sign_b : w_sign_a;
    assign o_exp_x  = w_a_ge_b ? w_exp_a : w_exp_b;
    assign w_exp_y  = w_a_ge_b ? w_exp_b : w_exp_a;
    assign o_man_x  = w_a_ge_b ? w_man_a : w_man_b;
    assign w_man_y  = w_a_ge_b ? w_man_b : w_man_a;

    assign w_diff  = o_exp_x - w_exp_y;
    assign o_man_y = (32'(w_diff) >= MAN_WIDTH + 32'd2) ? '0 : (w_man_y >> w_diff);

endmodule

// File: rtl/fp_addsub_ctrl.sv
// Multi-cycle FP add/sub sequencer: ALIGN, ADD, iterative NORM, then a held DONE result.
// Results truncate; overflow saturates to infinity; unnormalizable results flush to +0.
module fp_addsub_ctrl
    import fp_addsub_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int unsigned MAN_WIDTH = MAN_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0] b,
    input  logic                         op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0] result,
    output logic                         overflow,
    output logic                         zero
);
    localparam int unsigned W = fp_width(EXP_WIDTH, MAN_WIDTH);
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'(fp_exp_max(EXP_WIDTH));

    state_e               r_state, w_state_d;
    logic [W-1:0]         r_a, w_a_d, r_b, w_b_d, r_result, w_result_d;
    logic                 r_sign, w_sign_d, r_eff_sub, w_eff_sub_d;
    logic [EXP_WIDTH-1:0] r_exp, w_exp_d, w_exp_inc;
    logic [MAN_WIDTH:0]   r_man_x, w_man_x_d, r_man_y, w_man_y_d;
    logic [MAN_WIDTH+1:0] r_sum, w_sum_d;
    logic                 r_overflow, w_overflow_d, r_zero, w_zero_d;
    logic                 r_in_ready, w_in_ready_d, r_out_valid, w_out_valid_d;

    logic                 w_special, w_sign_x, w_sign_y, w_opp_tie;
    logic [EXP_WIDTH-1:0] w_exp_x;
    logic [MAN_WIDTH:0]   w_man_x, w_man_y;

    fp_exp_align #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_align (
        .i_a       (r_a),
        .i_b       (r_b),
        .o_special (w_special),
        .o_sign_x  (w_sign_x),
        .o_sign_y  (w_sign_y),
        .o_opp_tie (w_opp_tie),
        .o_exp_x   (w_exp_x),
        .o_man_x   (w_man_x),
        .o_man_y   (w_man_y)
    );

    assign w_exp_inc = r_exp + EXP_WIDTH'(1);

    always_comb begin
        w_state_d    = r_state;
        w_a_d        = r_a;
        w_b_d        = r_b;
        w_sign_d     = r_sign;
        w_eff_sub_d  = r_eff_sub;
        w_exp_d      = r_exp;
        w_man_x_d    = r_man_x;
        w_man_y_d    = r_man_y;
        w_sum_d      = r_sum;
        w_result_d   = r_result;
        w_overflow_d = r_overflow;
        w_zero_d     = r_zero;
        unique case (r_state)
            StIdle: begin
                if (in_valid && r_in_ready) begin
                    w_a_d     = a;
                    w_b_d     = {b[W-1] ^ op, b[W-2:0]};
                    w_state_d = StAlign;
                end
            end
            StAlign: begin
                if (w_special) begin
                    w_result_d   = {w_sign_x, EXP_MAX, {MAN_WIDTH{1'b0}}};
                    w_overflow_d = 1'b1;
                    w_zero_d     = 1'b0;
                    w_state_d    = StDone;
                end else begin
                    w_sign_d    = w_opp_tie ? 1'b0 : w_sign_x;
                    w_eff_sub_d = w_sign_x ^ w_sign_y;
                    w_exp_d     = w_exp_x;
                    w_man_x_d   = w_man_x;
                    w_man_y_d   = w_man_y;
                    w_state_d   = StAdd;
                end
            end
            StAdd: begin
                // X >= Y by magnitude, so the subtraction never goes negative.
                w_sum_d   = r_eff_sub ? ({1'b0, r_man_x} - {1'b0, r_man_y})
                                      : ({1'b0, r_man_x} + {1'b0, r_man_y});
                w_state_d = StNorm;
            end
            StNorm: begin
                w_state_d = StDone;
                if (r_sum == '0) begin
                    w_result_d   = '0;
                    w_overflow_d = 1'b0;
                    w_zero_d     = 1'b1;
                end else if (r_sum[MAN_WIDTH+1]) begin
                    w_zero_d = 1'b0;
                    if (w_exp_inc == EXP_MAX) begin
                        w_result_d   = {r_sign, EXP_MAX, {MAN_WIDTH{1'b0}}};
                        w_overflow_d = 1'b1;
                    end else begin
                        w_result_d   = {r_sign, w_exp_inc, r_sum[MAN_WIDTH:1]};
                        w_overflow_d = 1'b0;
                    end
                end else if (r_sum[MAN_WIDTH]) begin
                    w_result_d   = {r_sign, r_exp, r_sum[MAN_WIDTH-1:0]};
                    w_overflow_d = 1'b0;
                    w_zero_d     = 1'b0;
                end else if (r_exp > EXP_WIDTH'(1)) begin
                    w_sum_d   = r_sum << 1;
                    w_exp_d   = r_exp - EXP_WIDTH'(1);
                    w_state_d = StNorm;
                end else begin
                    w_result_d   = '0;
                    w_overflow_d = 1'b0;
                    w_zero_d     = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        // Handshake flags are registered from the next state so they follow state entry.
        w_in_ready_d  = (w_state_d == StIdle);
        w_out_valid_d = (w_state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_eff_sub   <= 1'b0;
            r_exp       <= '0;
            r_man_x     <= '0;
            r_man_y     <= '0;
            r_sum       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_a         <= w_a_d;
            r_b         <= w_b_d;
            r_sign      <= w_sign_d;
            r_eff_sub   <= w_eff_sub_d;
            r_exp       <= w_exp_d;
            r_man_x     <= w_man_x_d;
            r_man_y     <= w_man_y_d;
            r_sum       <= w_sum_d;
            r_result    <= w_result_d;
            r_overflow  <= w_overflow_d;
            r_zero      <= w_zero_d;
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
